// File: rtl/coredma_dsc_pkg.sv
// Shared sizing for the multi-channel descriptor cache: default geometry and derived widths.
package coredma_dsc_pkg;

    localparam int WIDTH_DEF    = 128;
    localparam int DEPTH_CH_DEF = 16;
    localparam int NUM_CH_DEF   = 4;

    // A single channel still needs a 1-bit select port.
    function automatic int ch_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CH_W   = ch_bits(NUM_CH_DEF);
    localparam int PTR_W  = ptr_bits(DEPTH_CH_DEF);
    localparam int ADDR_W = $clog2(NUM_CH_DEF * DEPTH_CH_DEF);

endpackage

// File: rtl/coredma_dsc_sdp_ram.sv
// Generic simple-dual-port RAM, one write port and one registered read port with enable.
// Read data appears the cycle after i_re and holds while i_re is low; the array has no reset.
module coredma_dsc_sdp_ram #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/coredma_dsc_cache_mc.sv
// Multi-channel descriptor cache: NUM_CH circular FIFOs sharing one SDP RAM, with flush and error pulses.
// Pop data is valid one cycle after acceptance; pushes to full / pops from empty channels are dropped and flagged.
module coredma_dsc_cache_mc
    import coredma_dsc_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH_CH = DEPTH_CH_DEF,
    parameter int NUM_CH   = NUM_CH_DEF,
    localparam int CW      = ch_bits(NUM_CH),
    localparam int LW      = $clog2(DEPTH_CH),
    localparam int PW      = ptr_bits(DEPTH_CH),
    localparam int AW      = $clog2(NUM_CH * DEPTH_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [CW-1:0]     i_push_ch,
    input  logic [WIDTH-1:0]  i_push_data,
    input  logic              i_pop,
    input  logic [CW-1:0]     i_pop_ch,
    input  logic [NUM_CH-1:0] i_flush,
    output logic              o_rd_valid,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic [CW-1:0]     o_rd_ch,
    output logic [NUM_CH-1:0] o_empty,
    output logic [NUM_CH-1:0] o_full,
    output logic              o_err_ovf,
    output logic              o_err_unf
);

    logic [NUM_CH-1:0]    w_push_acc;
    logic [NUM_CH-1:0]    w_pop_acc;
    logic [NUM_CH-1:0]    w_empty;
    logic [NUM_CH-1:0]    w_full;
    logic [NUM_CH*PW-1:0] w_wp_flat;
    logic [NUM_CH*PW-1:0] w_rp_flat;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PW-1:0] r_wp;
        logic [PW-1:0] r_rp;
        logic          r_empty;
        logic          r_full;
        logic [PW-1:0] w_wp_nxt;
        logic [PW-1:0] w_rp_nxt;

        // Acceptance uses the registered flags, i.e. pre-edge occupancy: no push-to-pop bypass.
        assign w_push_acc[c] = i_push && (i_push_ch == CW'(c)) && !r_full  && !i_flush[c];
        assign w_pop_acc[c]  = i_pop  && (i_pop_ch  == CW'(c)) && !r_empty && !i_flush[c];

        assign w_wp_nxt = r_wp + PW'(w_push_acc[c]);
        assign w_rp_nxt = r_rp + PW'(w_pop_acc[c]);

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_empty <= 1'b1;
                r_full  <= 1'b0;
            end else if (i_flush[c]) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_empty <= 1'b1;
                r_full  <= 1'b0;
            end else begin
                r_wp    <= w_wp_nxt;
                r_rp    <= w_rp_nxt;
                r_empty <= (w_wp_nxt == w_rp_nxt);
                r_full  <= (w_wp_nxt[LW-1:0] == w_rp_nxt[LW-1:0]) &&
                           (w_wp_nxt[PW-1]   != w_rp_nxt[PW-1]);
            end
        end

        assign w_empty[c]              = r_empty;
        assign w_full[c]               = r_full;
        assign w_wp_flat[c*PW +: PW]   = r_wp;
        assign w_rp_flat[c*PW +: PW]   = r_rp;
    end

    logic [PW-1:0]    w_wp_sel;
    logic [PW-1:0]    w_rp_sel;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic             w_push_any;
    logic             w_pop_any;
    logic             w_ovf;
    logic             w_unf;
    logic [WIDTH-1:0] w_ram_q;

    assign w_wp_sel   = w_wp_flat[i_push_ch*PW +: PW];
    assign w_rp_sel   = w_rp_flat[i_pop_ch*PW +: PW];
    // With a single channel the select bit falls off the top of the address.
    assign w_waddr    = AW'({i_push_ch, w_wp_sel[LW-1:0]});
    assign w_raddr    = AW'({i_pop_ch,  w_rp_sel[LW-1:0]});
    assign w_push_any = |w_push_acc;
    assign w_pop_any  = |w_pop_acc;

    // A request killed by flush is intentional, so it is not an error.
    assign w_ovf = i_push && w_full[i_push_ch] && !i_flush[i_push_ch];
    assign w_unf = i_pop  && w_empty[i_pop_ch] && !i_flush[i_pop_ch];

    coredma_dsc_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (NUM_CH * DEPTH_CH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_push_any),
        .i_waddr (w_waddr),
        .i_wdata (i_push_data),
        .i_re    (w_pop_any),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    logic          r_rd_valid;
    logic [CW-1:0] r_rd_ch;
    logic          r_rd_seen;
    logic          r_err_ovf;
    logic          r_err_unf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_ch    <= '0;
            r_rd_seen  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_any;
            r_err_ovf  <= w_ovf;
            r_err_unf  <= w_unf;
            if (w_pop_any) begin
                r_rd_ch   <= i_pop_ch;
                r_rd_seen <= 1'b1;
            end
        end
    end

    // The RAM read register is unreset; gate it so reset shows zero until the first pop lands.
    assign o_rd_data  = r_rd_seen ? w_ram_q : '0;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_ch    = r_rd_ch;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_err_ovf  = r_err_ovf;
    assign o_err_unf  = r_err_unf;

endmodule

// File: doc/coredma_dsc_cache_mc.md
# coredma_dsc_cache_mc

Multi-channel descriptor cache for the DMA controller. One shared simple-dual-port RAM is partitioned into NUM_CH independent circular FIFOs of DEPTH_CH descriptors each. Fetch logic pushes descriptors into a channel's queue. The channel arbiter pops them with a fixed one-cycle registered read latency. It supersedes the single-queue, address-driven descriptor cache RAM and adds per-channel pointers, full/empty status, per-channel flush and overflow/underflow error reporting.

## Interface
- WIDTH, 128, descriptor width in bits
- DEPTH_CH, 16, descriptors per channel; power of two, ≥2
- NUM_CH, 4, channel count; power of two, ≥1
- CLOCK  in  1  single clock; all logic is rising-edge
- RESET  in  1  asynchronous, active-high reset
- PUSH  in  1  write request
- PUSH_CH  in  clog2(NUM_CH)  target channel of the write (width is 1 when NUM_CH=1)
- PUSH_DATA  in  WIDTH  descriptor to store
- POP  in  1  read request
- POP_CH  in  clog2(NUM_CH)  source channel of the read
- FLUSH  in  NUM_CH  per-channel flush, one-hot or multi-hot
- RD_VALID  out  1  RD_DATA/RD_CH hold a popped descriptor this cycle
- RD_DATA  out  WIDTH  popped descriptor
- RD_CH  out  clog2(NUM_CH)  channel that RD_DATA came from
- EMPTY  out  NUM_CH  channel queue holds 0 entries
- FULL  out  NUM_CH  channel queue holds DEPTH_CH entries
- ERR_OVF  out  1  one-cycle pulse: push to a full channel was dropped
- ERR_UNF  out  1  one-cycle pulse: pop from an empty channel was dropped

## Operation
- Each channel has a write pointer and a read pointer, each clog2(DEPTH_CH)+1 bits wide. The MSB is a wrap bit.
- A channel is empty when its pointers are equal. It is full when the low bits are equal and the MSBs differ.
- RAM address is {channel, ptr[low bits]}. Total RAM depth is NUM_CH*DEPTH_CH.
- Push is accepted when PUSH=1, FULL[PUSH_CH]=0 and FLUSH[PUSH_CH]=0. On acceptance the RAM is written and the write pointer increments modulo 2·DEPTH_CH.
- Pop is accepted when POP=1, EMPTY[POP_CH]=0 and FLUSH[POP_CH]=0. On acceptance the RAM is read and the read pointer increments.
- Push to the same channel in the same cycle is allowed. EMPTY and FULL are evaluated from pre-edge state.
  - A pop on an empty channel is rejected even if a push to that channel occurs in the same cycle. There is no bypass.
  - A push on a full channel is rejected even with a simultaneous pop.
- A rejected push pulses ERR_OVF the following cycle. A rejected pop pulses ERR_UNF the following cycle. A request dropped because of FLUSH raises no error.
- FLUSH[c] sets both pointers of channel c to 0 at the next edge. Flush takes priority over a push or pop to c in the same cycle. RAM contents are not cleared.
- Push and pop to different channels are fully independent in the same cycle.
- The RAM has no reset. Reading it is only possible through accepted pops, so only written data is ever returned.

## Timing
- Reset values: all pointers 0, EMPTY all 1, FULL all 0, RD_VALID 0, RD_DATA 0, RD_CH 0, ERR_OVF 0, ERR_UNF 0.
- Pop latency is 1. For a pop accepted at edge N, RD_VALID=1 with RD_DATA/RD_CH valid after edge N+1, for exactly one cycle unless popped again.
- Back-to-back pops every cycle are supported; throughput is 1 descriptor/cycle.
- EMPTY/FULL are registered and reflect the pointer state after the edge.
- A push at edge N is poppable at edge N+1. It appears on RD_DATA after edge N+2.
- Read-during-write to the same RAM address cannot occur, because the pointer rules prevent it.
- When RESET asserts mid-transfer, all outputs go to their reset values immediately. An in-flight RD_VALID is lost.
- RD_DATA holds its last value when RD_VALID=0.

## Structure
- Package coredma_dsc_pkg holds clog2-derived localparams: CH_W, PTR_W, ADDR_W.
- Sub-module coredma_dsc_sdp_ram is a generic WIDTH × (NUM_CH·DEPTH_CH) simple-dual-port RAM.
  - Registered read with a read enable; no reset on the array.
  - It is the only technology-mappable part.
- Pointer, flag and error logic live in the top module, with pointers held in a generate-loop per channel.

## Test plan
- Reset, then push 0xA0..0xA3 to ch2 and pop ch2 four times → RD_DATA 0xA0,0xA1,0xA2,0xA3 on consecutive cycles with RD_CH=2. EMPTY[2] returns to 1.
- Push 16 entries to ch0 (DEPTH_CH=16), then a 17th → FULL[0]=1, one ERR_OVF pulse, and the 17th value is never returned.
- Pop ch1 while empty, with a simultaneous push to ch1 → ERR_UNF pulses once, the push is stored, and the next pop returns the pushed value.
- Fill ch3 to 16, then push and pop ch3 in the same cycle → pop returns the oldest entry, the push is dropped with ERR_OVF, and ch3 ends with 15 entries.
- Wrap: push/pop 40 descriptors through ch0 with occupancy ≤3 → data order is preserved and pointer MSB toggles are handled with no false FULL/EMPTY.
- FLUSH[1] with a simultaneous push to ch1 and a pop from ch0 → ch1 becomes EMPTY with no error, and the ch0 pop completes normally.
- Assert RESET during an RD_VALID cycle → RD_VALID drops immediately and all EMPTY bits read 1.
